ram_stream_reader: RTL
======================

# ram_stream_reader

Read engine for the dual-port distributed RAMs in the Malloc/RAM library. It accepts a (start address, length) command over a valid/ready handshake. It then sweeps the RAM's asynchronous read port and delivers the words as a registered valid/ready stream with a last marker. It sits between a RAM's second read port and any downstream consumer (DMA, serializer, FIFO), while a separate writer owns the RAM's write port.

## Interface
- ADDR_WIDTH, 6, RAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 16, RAM word width.
- LEN_WIDTH, 7, command length width; must be ≥ ADDR_WIDTH+1 so a full-depth sweep is expressible.
- clk  in  1  single clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, so a command can be accepted.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  number of words to read.
- rd_addr  out  ADDR_WIDTH  address to the RAM asynchronous read port; registered.
- rd_data  in  DATA_WIDTH  RAM read data, combinational from rd_addr in the same cycle.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_WIDTH  output word; registered.
- m_last  out  1  marks the final word of the command.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- The state machine has two states, IDLE and STREAM.
  - IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch ptr←cmd_addr and remaining←cmd_len.
    - If cmd_len≠0, go to STREAM.
    - If cmd_len=0, stay in IDLE, emit no beats, and pulse done on the next cycle.
  - STREAM: cmd_ready=0. The output register may load when load_en = (remaining≠0) & (!m_valid | m_ready).
  - On load_en:
    - m_data←rd_data, m_valid←1, m_last←(remaining==1).
    - ptr←ptr+1, remaining←remaining−1.
  - When m_valid&m_ready and no load occurs in the same cycle: m_valid←0.
  - When m_valid&m_ready&m_last: done pulses on the following cycle and the state returns to IDLE.
- rd_addr = ptr at all times.
- Address arithmetic is modulo 2^ADDR_WIDTH, so reads wrap from 2^ADDR_WIDTH−1 to 0. Lengths above the depth are legal and re-read wrapped words.
- m_data, m_last and m_valid hold steady while m_valid&!m_ready (AXI-stream style).
- m_valid is never retracted without a handshake, except on reset.
- The RAM word is sampled at its load edge. The engine gives no coherence guarantee against concurrent writes to addresses that have not yet been read.
- Reset values: state=IDLE, cmd_ready=1, m_valid=0, m_last=0, m_data=0, rd_addr=0, busy=0, done=0, ptr=0, remaining=0.
- Reset mid-stream drops the transfer. The stream is not resumed and done does not pulse.

## Timing
- Command accepted at edge k: rd_addr=cmd_addr after k, and the first m_valid=1 after edge k+1.
- With m_ready held high, the engine sustains one word per cycle. An N-word command completes its last handshake at edge k+N+1, and done=1 in the cycle after that edge.
- cmd_ready rises in the same cycle that done is high. There is one idle cycle between back-to-back commands.
- Backpressure: while m_ready=0 with m_valid=1, ptr and remaining freeze.
- All outputs are registered; there are no combinational paths from m_ready, cmd_valid or rd_data to outputs.

## Structure
- Shared package (ram_pkg): state enum {IDLE, STREAM}, and the default widths RAM_ADDR_W=6 and RAM_DATA_W=16 reused by the RAM library.
- No sub-module is needed inside the block. The bench instantiates the library's 64×16 async-read dual-port RAM, with its write port driven by the testbench and its second read port driven by rd_addr.

## Test plan
- Preload RAM[i]=i+0x100. Command addr=4, len=3, m_ready=1 → data 0x104, 0x105, 0x106 on consecutive cycles; m_last on 0x106; done one cycle later.
- Command addr=62, len=4 → data 0x13E, 0x13F, 0x100, 0x101 (wrap-around); m_last on the fourth beat.
- Command addr=0, len=8 with m_ready toggling 1,0,0,1,… → all 8 words delivered in order; m_data stable during every stall; no duplicates or drops.
- Command len=0 → no m_valid; done pulses; cmd_ready returns to 1 with no stall.
- Assert RST after 2 of 10 beats → next cycle m_valid=0, busy=0, cmd_ready=1, no done. A new command addr=10, len=1 then returns 0x10A.
- Command addr=0, len=64 followed immediately by addr=0, len=2 held on cmd_valid → the second command is accepted exactly when done of the first is high, and its first beat is 0x100.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the Malloc/RAM library.
// Provides:
//   RAM_ADDR_W, RAM_DATA_W : default address / data widths of the library RAMs
//   state_t                : ram_stream_reader FSM state encoding {IDLE, STREAM}
package ram_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/ram_dp_async.sv
// ram_dp_async: library dual-port distributed RAM, one synchronous write port
// and two asynchronous (combinational) read ports.
// Ports:
//   clk              : write clock
//   we, waddr, wdata : write port, written on the rising edge when we=1
//   raddr_a/rdata_a  : read port A, combinational
//   raddr_b/rdata_b  : read port B, combinational
module ram_dp_async
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH = RAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads cmd_len words starting at cmd_addr from a RAM
// asynchronous read port and delivers them as a registered stream.
// Ports:
//   clk, RST                    : clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : command handshake (cmd_addr, cmd_len)
//   rd_addr / rd_data           : RAM async read port (registered address)
//   m_valid/m_ready             : output stream handshake (m_data, m_last)
//   busy                        : high while streaming (exposes FSM state)
//   done                        : one-cycle pulse after a command completes
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload steady until that edge
// and never drops valid without a transfer (reset excepted).
//
// LEN_WIDTH must be at least ADDR_WIDTH+1 so a full-depth sweep fits.
module ram_stream_reader
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH = RAM_DATA_W,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  load_en;

  // The output register takes a new word whenever one is still owed and the
  // register is empty or being drained this cycle.
  assign load_en = (state == STREAM) && (remaining != '0) && (!m_valid || m_ready);

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len != '0) begin
              state <= STREAM;
            end else begin
              // Empty command: nothing to stream, just report completion.
              done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (load_en) begin
            m_data    <= rd_data;
            m_valid   <= 1'b1;
            m_last    <= (remaining == LEN_WIDTH'(1));
            // Wraps naturally modulo the RAM depth.
            ptr       <= ptr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
          end
          if (m_valid && m_ready && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == STREAM);
  assign rd_addr   = ptr;

endmodule
